// File: rtl/button_event_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// button_event_ctrl_pkg : shared debounce FSM state encoding and helpers
// Revision: 1.0
// ============================================================================
package button_event_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } btn_state_e;

  // Debounced level is high while the button is considered down.
  function automatic logic is_level(input btn_state_e st);
    return (st == ST_HELD) || (st == ST_DB_RELEASE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_ctrl_if.sv
`default_nettype none
// ============================================================================
// button_event_ctrl_if : control inputs and event outputs of button_event_ctrl
// Revision: 1.0
// ============================================================================
interface button_event_ctrl_if #(
  parameter int N_BTN = 4
);
  logic             i_en;
  logic [N_BTN-1:0] i_repeat_en;
  logic [N_BTN-1:0] i_btn_raw;
  logic [N_BTN-1:0] o_btn_level;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_long_press;
  logic [N_BTN-1:0] o_repeat_p;
  logic             o_event_any;

  modport master (
    output i_en, i_repeat_en, i_btn_raw,
    input  o_btn_level, o_press, o_release, o_long_press, o_repeat_p, o_event_any
  );

  modport slave (
    input  i_en, i_repeat_en, i_btn_raw,
    output o_btn_level, o_press, o_release, o_long_press, o_repeat_p, o_event_any
  );
endinterface
`default_nettype wire

// File: rtl/button_event_ctrl_clock_divider.sv
`default_nettype none
// ============================================================================
// button_event_ctrl_clock_divider : one-cycle tick every DVSR clocks while enabled
// Revision: 1.0
// ============================================================================
module button_event_ctrl_clock_divider #(
  parameter int DVSR = 2000000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_en,
  output logic      o_tick
);
  localparam int                 c_W    = $clog2(DVSR);
  localparam logic [c_W-1:0]     c_LAST = c_W'(DVSR - 1);

  logic [c_W-1:0] r_cnt;

  // Count restarts from zero whenever the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!i_en || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// button_event_ctrl : shared-timebase debounce and press/release/long/repeat events
// Revision: 1.0
// ============================================================================
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int DVSR         = 2000000,
  parameter int CNT_W        = 8,
  parameter int LONG_TICKS   = 50,
  parameter int REPEAT_TICKS = 10
) (
  input wire logic          clk,
  input wire logic          rst_n,
  button_event_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] c_LONG = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] c_REP  = CNT_W'(REPEAT_TICKS);

  logic             w_tick;
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press_v;
  logic [N_BTN-1:0] w_release_v;
  logic [N_BTN-1:0] w_long_v;
  logic [N_BTN-1:0] w_rep_v;
  logic             r_event_any;

  button_event_ctrl_clock_divider #(
    .DVSR (DVSR)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (bus.i_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0] r_rep;
    logic [CNT_W-1:0] w_rep_nxt;
    logic             w_s;
    logic             w_press;
    logic             w_release;
    logic             w_long;
    logic             w_repeat;
    logic             r_press;
    logic             r_release;
    logic             r_long;
    logic             r_repeat;

    assign w_s = r_sync2[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state   <= ST_IDLE;
        r_hold    <= '0;
        r_rep     <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
        r_repeat  <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_hold    <= w_hold_nxt;
        r_rep     <= w_rep_nxt;
        r_press   <= w_press;
        r_release <= w_release;
        r_long    <= w_long;
        r_repeat  <= w_repeat;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_rep_nxt   = r_rep;
      w_press     = 1'b0;
      w_release   = 1'b0;
      w_long      = 1'b0;
      w_repeat    = 1'b0;
      if (!bus.i_en) begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
        w_rep_nxt   = '0;
      end else if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (w_s) w_state_nxt = ST_DB_PRESS;
          end
          ST_DB_PRESS: begin
            if (w_s) begin
              w_state_nxt = ST_HELD;
              w_press     = 1'b1;
              w_hold_nxt  = '0;
              w_rep_nxt   = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
          ST_HELD: begin
            // Hold count saturates at the long-press point; repeat count takes over after it.
            if (!w_s) begin
              w_state_nxt = ST_DB_RELEASE;
            end else if (r_hold < c_LONG) begin
              w_hold_nxt = r_hold + 1'b1;
              w_long     = (r_hold == c_LONG - 1'b1);
            end else if (r_rep == c_REP - 1'b1) begin
              w_rep_nxt = '0;
              w_repeat  = bus.i_repeat_en[i];
            end else begin
              w_rep_nxt = r_rep + 1'b1;
            end
          end
          ST_DB_RELEASE: begin
            if (w_s) begin
              w_state_nxt = ST_HELD;
            end else begin
              w_state_nxt = ST_IDLE;
              w_release   = 1'b1;
            end
          end
          default: w_state_nxt = ST_IDLE;
        endcase
      end
    end

    assign w_level[i]     = is_level(r_state);
    assign w_press_v[i]   = r_press;
    assign w_release_v[i] = r_release;
    assign w_long_v[i]    = r_long;
    assign w_rep_v[i]     = r_repeat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_event_any <= 1'b0;
    end else begin
      r_event_any <= |(w_press_v | w_release_v | w_long_v | w_rep_v);
    end
  end

  assign bus.o_btn_level  = w_level;
  assign bus.o_press      = w_press_v;
  assign bus.o_release    = w_release_v;
  assign bus.o_long_press = w_long_v;
  assign bus.o_repeat_p   = w_rep_v;
  assign bus.o_event_any  = r_event_any;
endmodule
`default_nettype wire
